// File: rtl/pwm_dac_multi.sv
// Multi-channel pulse-width DAC. Each channel holds a W-bit offset-binary value
// split into SEGS segments of SEGBITS bits; every segment drives one PWM output
// compared against a shared free-running counter. Writes land in a staging
// register and are transferred to the active register either immediately or at
// the period wrap, so a PWM period never sees a half-updated value.
module pwm_dac_multi #(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned SEGBITS   = 7,
  parameter int unsigned SEGS      = 2,
  parameter int unsigned SIGNED    = 1,
  parameter int unsigned SYNC_LOAD = 1
) (
  input  logic                                          XCK,
  input  logic                                          RESET,
  input  logic                                          DACWRL,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] CHAN,
  input  logic [15:0]                                   D,
  output logic [CHANNELS*SEGS-1:0]                      PW,
  output logic [CHANNELS*SEGS*SEGBITS-1:0]              DAC,
  output logic                                          PERIOD,
  output logic [CHANNELS-1:0]                           PEND
);

  localparam int unsigned W     = SEGS * SEGBITS;
  localparam int unsigned ChanW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // Midscale doubles as the MSB mask that converts two's complement to offset binary.
  localparam logic [W-1:0] MidScale = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MsbFlip  = (SIGNED != 0) ? MidScale : '0;

  logic [SEGBITS-1:0]              cnt_q, cnt_d;
  logic [CHANNELS-1:0][W-1:0]      stage_q, stage_d;
  logic [CHANNELS-1:0][W-1:0]      active_q, active_d;
  logic [CHANNELS-1:0]             pend_q, pend_d;
  logic [CHANNELS*SEGS-1:0]        pw_q, pw_d;
  logic [CHANNELS-1:0]             wr_en;
  logic [W-1:0]                    sample;
  logic                            wrap;
  logic                            unused_d;

  // The low bus bits below the sample are intentionally ignored.
  assign unused_d = ^D;

  assign sample = D[15 -: W] ^ MsbFlip;
  assign wrap   = (cnt_q == '1);

  // Per-channel write strobe; a select beyond the last channel matches nothing.
  always_comb begin
    wr_en = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      wr_en[c] = ~DACWRL && (CHAN == ChanW'(c));
    end
  end

  // Next-state: counter, staging/active transfer, pending flags and PWM compares.
  always_comb begin
    cnt_d    = cnt_q + SEGBITS'(1);
    stage_d  = stage_q;
    active_d = active_q;
    pend_d   = pend_q;
    pw_d     = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (wr_en[c]) begin
        stage_d[c] = sample;
      end
      if (SYNC_LOAD != 0) begin
        if (wrap) begin
          // A write on the wrap edge is forwarded straight into the active value.
          if (wr_en[c]) begin
            active_d[c] = sample;
          end else if (pend_q[c]) begin
            active_d[c] = stage_q[c];
          end
          pend_d[c] = 1'b0;
        end else if (wr_en[c]) begin
          pend_d[c] = 1'b1;
        end
      end else begin
        if (wr_en[c]) begin
          active_d[c] = sample;
        end
        pend_d[c] = 1'b0;
      end
      for (int s = 0; s < SEGS; s++) begin
        pw_d[c*SEGS + s] = (cnt_q < active_q[c][s*SEGBITS +: SEGBITS]);
      end
    end
  end

  // State registers with synchronous reset to midscale silence.
  always_ff @(posedge XCK) begin
    if (RESET) begin
      cnt_q    <= '0;
      stage_q  <= {CHANNELS{MidScale}};
      active_q <= {CHANNELS{MidScale}};
      pend_q   <= '0;
      pw_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      stage_q  <= stage_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      pw_q     <= pw_d;
    end
  end

  assign PW     = pw_q;
  assign DAC    = active_q;
  assign PEND   = pend_q;
  assign PERIOD = wrap;

endmodule

// File: tb/tb_pwm_dac_multi.sv
// Bench for pwm_dac_multi: a default synchronous-load signed instance plus a
// three-channel immediate-load unsigned instance, checked every cycle against
// an arithmetic reference model, with directed sequences and a vector table.
module tb_pwm_dac_multi;

  logic        clk;
  logic        rst;
  logic        wrl, wrl3;
  logic        chan;
  logic [1:0]  chan3;
  logic [15:0] d, d3;

  logic [3:0]  pw;
  logic [27:0] dac;
  logic        period;
  logic [1:0]  pend;
  logic [5:0]  pw3;
  logic [41:0] dac3;
  logic        period3;
  logic [2:0]  pend3;

  pwm_dac_multi u_dut (
    .XCK    (clk),
    .RESET  (rst),
    .DACWRL (wrl),
    .CHAN   (chan),
    .D      (d),
    .PW     (pw),
    .DAC    (dac),
    .PERIOD (period),
    .PEND   (pend)
  );

  pwm_dac_multi #(
    .CHANNELS  (3),
    .SIGNED    (0),
    .SYNC_LOAD (0)
  ) u_dut3 (
    .XCK    (clk),
    .RESET  (rst),
    .DACWRL (wrl3),
    .CHAN   (chan3),
    .D      (d3),
    .PW     (pw3),
    .DAC    (dac3),
    .PERIOD (period3),
    .PEND   (pend3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int          m_cnt;
  logic [13:0] m_stage  [2];
  logic [13:0] m_active [2];
  logic [1:0]  m_pend;
  logic [3:0]  m_pw;
  logic [13:0] m3 [3];

  typedef struct {
    logic        wrl;
    logic [1:0]  chan;
    logic [15:0] d;
    logic [41:0] exp;
  } vec_t;
  vec_t tbl [7];

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Advance the model by one clock edge using the inputs presented at that edge.
  task automatic model_step();
    logic [13:0] val;
    if (rst) begin
      m_cnt  = 0;
      m_pend = '0;
      m_pw   = '0;
      for (int c = 0; c < 2; c++) begin
        m_stage[c]  = 14'h2000;
        m_active[c] = 14'h2000;
      end
      for (int c = 0; c < 3; c++) m3[c] = 14'h2000;
      return;
    end
    for (int c = 0; c < 2; c++)
      for (int s = 0; s < 2; s++)
        m_pw[c*2 + s] = (m_cnt < ((int'(m_active[c]) >> (7 * s)) % 128));
    val = d[15:2] ^ 14'h2000;
    for (int c = 0; c < 2; c++) begin
      if (!wrl && int'(chan) == c) begin
        m_stage[c] = val;
        m_pend[c]  = 1'b1;
      end
      if (m_cnt == 127 && m_pend[c]) begin
        m_active[c] = m_stage[c];
        m_pend[c]   = 1'b0;
      end
    end
    if (!wrl3 && int'(chan3) < 3) m3[int'(chan3)] = d3[15:2];
    m_cnt = (m_cnt + 1) % 128;
  endtask

  task automatic check_all();
    check("dac",     64'(dac),     64'({m_active[1], m_active[0]}));
    check("pw",      64'(pw),      64'(m_pw));
    check("pend",    64'(pend),    64'(m_pend));
    check("period",  64'(period),  64'(m_cnt == 127));
    check("dac3",    64'(dac3),    64'({m3[2], m3[1], m3[0]}));
    check("pend3",   64'(pend3),   64'(0));
    check("period3", 64'(period3), 64'(m_cnt == 127));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic run_to(input int target);
    while (m_cnt != target) cycle();
  endtask

  task automatic run_to_wrap();
    run_to(127);
    cycle();
  endtask

  task automatic write1(input logic ch, input logic [15:0] v);
    wrl  = 1'b0;
    chan = ch;
    d    = v;
    cycle();
    wrl  = 1'b1;
  endtask

  int hi0, hi1, hi2, hi3, nper;

  initial begin
    tbl[0] = '{1'b0, 2'd2, 16'h8000, {14'h2000, 14'h2000, 14'h2000}};
    tbl[1] = '{1'b0, 2'd0, 16'hFFFC, {14'h2000, 14'h2000, 14'h3FFF}};
    tbl[2] = '{1'b0, 2'd1, 16'h0004, {14'h2000, 14'h0001, 14'h3FFF}};
    tbl[3] = '{1'b0, 2'd3, 16'h1234, {14'h2000, 14'h0001, 14'h3FFF}};
    tbl[4] = '{1'b0, 2'd2, 16'h4000, {14'h1000, 14'h0001, 14'h3FFF}};
    tbl[5] = '{1'b1, 2'd1, 16'hFFFF, {14'h1000, 14'h0001, 14'h3FFF}};
    tbl[6] = '{1'b0, 2'd0, 16'h0003, {14'h1000, 14'h0001, 14'h0000}};

    rst = 1'b1; wrl = 1'b1; wrl3 = 1'b1;
    chan = 1'b0; chan3 = 2'd0; d = 16'h0; d3 = 16'h0;

    // Reset defaults, then one full period of midscale duty.
    cycle();
    cycle();
    check("rst_pw", 64'(pw), 64'(0));
    check("rst_dac", 64'(dac), 64'({14'h2000, 14'h2000}));
    rst = 1'b0;
    hi0 = 0; hi1 = 0; nper = 0;
    repeat (128) begin
      cycle();
      hi0 += int'(pw[0]);
      hi1 += int'(pw[1]);
      nper += int'(period);
    end
    check("mid_pw0_high", 64'(hi0), 64'(0));
    check("mid_pw1_high", 64'(hi1), 64'(64));
    check("mid_period_cnt", 64'(nper), 64'(1));

    // Full scale on channel 0.
    write1(1'b0, 16'h7FFC);
    check("fs_pend", 64'(pend), 64'(2'b01));
    run_to_wrap();
    check("fs_dac0", 64'(dac[13:0]), 64'(14'h3FFF));
    check("fs_dac1", 64'(dac[27:14]), 64'(14'h2000));
    check("fs_pend_clr", 64'(pend), 64'(0));
    hi0 = 0; hi1 = 0; hi2 = 0; hi3 = 0;
    repeat (128) begin
      cycle();
      hi0 += int'(pw[0]); hi1 += int'(pw[1]);
      hi2 += int'(pw[2]); hi3 += int'(pw[3]);
    end
    check("fs_pw0_high", 64'(hi0), 64'(127));
    check("fs_pw1_high", 64'(hi1), 64'(127));
    check("fs_pw2_high", 64'(hi2), 64'(0));
    check("fs_pw3_high", 64'(hi3), 64'(64));

    // Negative full scale.
    write1(1'b0, 16'h8000);
    run_to_wrap();
    check("zs_dac0", 64'(dac[13:0]), 64'(0));
    hi0 = 0;
    repeat (128) begin
      cycle();
      hi0 += int'(pw[0]) + int'(pw[1]);
    end
    check("zs_pw_high", 64'(hi0), 64'(0));
    check("zs_dac1", 64'(dac[27:14]), 64'(14'h2000));

    // Period-synchronised load with a superseding second write.
    run_to(40);
    write1(1'b1, 16'h0000);
    check("sync_pend_a", 64'(pend), 64'(2'b10));
    check("sync_dac1_a", 64'(dac[27:14]), 64'(14'h2000));
    run_to(50);
    write1(1'b1, 16'h4000);
    check("sync_pend_b", 64'(pend), 64'(2'b10));
    check("sync_dac1_b", 64'(dac[27:14]), 64'(14'h2000));
    run_to(127);
    check("sync_pend_prewrap", 64'(pend), 64'(2'b10));
    cycle();
    check("sync_dac1_c", 64'(dac[27:14]), 64'(14'h3000));
    check("sync_pend_c", 64'(pend), 64'(0));

    // Write coinciding with the wrap edge is forwarded.
    run_to(127);
    write1(1'b0, 16'h4000);
    check("wrapw_dac0", 64'(dac[13:0]), 64'(14'h3000));
    check("wrapw_pend", 64'(pend), 64'(0));

    // Reset with a pending write discards it.
    run_to(90);
    write1(1'b0, 16'h7FFC);
    check("mr_pend_set", 64'(pend), 64'(2'b01));
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mr_pend", 64'(pend), 64'(0));
    check("mr_dac", 64'(dac), 64'({14'h2000, 14'h2000}));
    check("mr_pw", 64'(pw), 64'(0));
    run_to_wrap();
    check("mr_dac0_lost", 64'(dac[13:0]), 64'(14'h2000));

    // Immediate-load unsigned instance, vector table.
    for (int i = 0; i < 7; i++) begin
      wrl3  = tbl[i].wrl;
      chan3 = tbl[i].chan;
      d3    = tbl[i].d;
      cycle();
      wrl3  = 1'b1;
      check($sformatf("vec%0d_dac3", i), 64'(dac3), 64'(tbl[i].exp));
    end

    // Randomised traffic on both instances, including writes during reset.
    repeat (1500) begin
      rst   = ($urandom_range(0, 299) == 0);
      wrl   = ($urandom_range(0, 9) != 0);
      chan  = 1'($urandom_range(0, 1));
      d     = 16'($urandom);
      wrl3  = ($urandom_range(0, 4) != 0);
      chan3 = 2'($urandom_range(0, 3));
      d3    = 16'($urandom);
      cycle();
    end
    rst = 1'b0; wrl = 1'b1; wrl3 = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
